ifu_axi_fetch: RTL

//  Instruction-fetch AXI4 read master. Upstream of the depth-1 fetch FIFO.
//  - Accepts one fetch address from the PC generator.
//  - Issues a single-beat AXI4 read for that address.
//  - Selects the 32-bit instruction from the 64-bit beat.
//  - Pushes {pc, inst, err} into the FIFO.
//  - On flush, discards any in-flight response while still completing the AXI transaction legally.

---
 rtl/ifu_axi_fetch_if.sv | 42 ++++
 rtl/ifu_axi_fetch.sv | 97 +++++++++
 2 files changed

// File: rtl/ifu_axi_fetch_if.sv
// Signal bundle around the instruction-fetch AXI read master.
// It covers the PC-generator request, the AXI4 AR/R channels and the fetch-FIFO write port.
interface ifu_axi_fetch_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    localparam int FIFO_WIDTH = ADDR_WIDTH + 33;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    logic                  fifo_empty;
    logic                  fifo_write;
    logic [FIFO_WIDTH-1:0] fifo_in;

    modport master (
        input  req_valid, req_addr, arready, rvalid, rdata, rresp, rlast, fifo_empty,
        output req_ready, arvalid, araddr, arid, arlen, arsize, arburst, rready,
               fifo_write, fifo_in
    );

    modport slave (
        output req_valid, req_addr, arready, rvalid, rdata, rresp, rlast, fifo_empty,
        input  req_ready, arvalid, araddr, arid, arlen, arsize, arburst, rready,
               fifo_write, fifo_in
    );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch AXI4 read master: one single-beat read per fetch PC.
// It selects the 32-bit instruction from the 64-bit beat and pushes {pc, inst, err} into the fetch FIFO.
module ifu_axi_fetch #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    ifu_axi_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, PUSH} state_t;

    state_t                state, state_nxt;
    logic                  drop, drop_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [31:0]           inst, inst_nxt;
    logic                  err, err_nxt;
    logic                  unused_rlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            drop  <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drop_nxt       = drop;
        pc_nxt         = pc;
        inst_nxt       = inst;
        err_nxt        = err;
        bus.req_ready  = 1'b0;
        bus.arvalid    = 1'b0;
        bus.rready     = 1'b0;
        bus.fifo_write = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = ~flush;
                if (bus.req_valid && !flush) begin
                    pc_nxt    = bus.req_addr;
                    state_nxt = ADDR;
                end
            end
            // A flush here cannot retract arvalid, so the response is marked for discard instead.
            ADDR: begin
                bus.arvalid = 1'b1;
                if (flush)
                    drop_nxt = 1'b1;
                if (bus.arready)
                    state_nxt = DATA;
            end
            DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    if (drop || flush) begin
                        drop_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        inst_nxt  = pc[2] ? bus.rdata[63:32] : bus.rdata[31:0];
                        err_nxt   = (bus.rresp != 2'b00);
                        state_nxt = PUSH;
                    end
                end else if (flush) begin
                    drop_nxt = 1'b1;
                end
            end
            PUSH: begin
                bus.fifo_write = bus.fifo_empty & ~flush;
                if (flush || bus.fifo_empty)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.araddr  = {pc[ADDR_WIDTH-1:3], 3'b000};
    assign bus.arid    = ID_WIDTH'(AXI_ID);
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'b011;
    assign bus.arburst = 2'b01;
    assign bus.fifo_in = {pc, inst, err};

    // Every read is a single beat, so rlast carries no information.
    assign unused_rlast = bus.rlast;
endmodule
